// File: rtl/aes_sub_bytes.sv
// AES-128 SubBytes: 16 parallel FIPS-197 forward S-box lookups feeding a
// registered output with a valid flag (1-cycle latency, one state per clock).
module aes_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [127:0] w_sub;
  logic [127:0] r_out;
  logic         r_out_valid;

  for (genvar g = 0; g < 16; g++) begin : g_lane
    assign w_sub[8*g +: 8] = SBOX[in[8*g +: 8]];
  end

  // Data register only loads on in_valid so an idle (possibly X) input never reaches out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 128'h0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_out <= w_sub;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes against an S-box model derived from
// GF(2^8) inversion and the FIPS-197 affine transform.
module tb_aes_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in;
  logic         out_valid;
  logic [127:0] out;

  int checks = 0;
  int errors = 0;

  logic [7:0]   ref_tab [256];
  logic [127:0] exp_q [$];
  logic [127:0] m_out;
  logic         m_valid;

  aes_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    if (a == 8'h0) return 8'h0;
    for (int c = 1; c < 256; c++)
      if (gf_mul(a, 8'(c)) == 8'h01) return 8'(c);
    return 8'h0;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] b = gf_inv(a);
    logic [7:0] cc = 8'h63;
    logic [7:0] r;
    for (int k = 0; k < 8; k++)
      r[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ cc[k];
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver: one clock per call, then score the registered outputs
  task automatic step(input logic v, input logic [127:0] d);
    logic [127:0] e;
    @(negedge clk);
    in_valid = v;
    in       = v ? d : 'x;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_out   = 128'h0;
      m_valid = 1'b0;
    end else if (v) begin
      m_valid = 1'b1;
      exp_q.push_back(model_state(d));
    end else begin
      m_valid = 1'b0;
    end
    check("out_valid", {127'h0, out_valid}, {127'h0, m_valid});
    if (m_valid && exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      m_out = e;
      check("out_data", out, e);
    end else begin
      check("out_hold", out, m_out);
    end
  endtask

  localparam logic [127:0] VEC1_IN  = 128'h00000101030307070f0f1f1f3f3f6f8f;
  localparam logic [127:0] VEC1_OUT = 128'h63637c7c7b7bc5c57676c0c07575a873;
  localparam logic [127:0] VEC2_IN  = 128'h0c2c341c9ca0fe14c90d2881a92d7721;
  localparam logic [127:0] VEC2_OUT = 128'hfe71189cdee0bbfaddd7340cd3d8f5fd;

  initial begin
    logic [127:0] s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    m_out    = 128'h0;
    m_valid  = 1'b0;
    for (int v = 0; v < 256; v++) ref_tab[v] = model_sbox(8'(v));

    // model anchors from the FIPS-197 table
    check("anchor_00", {120'h0, ref_tab[8'h00]}, 128'h63);
    check("anchor_53", {120'h0, ref_tab[8'h53]}, 128'hed);
    check("anchor_ff", {120'h0, ref_tab[8'hff]}, 128'h16);

    // reset held with active input
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rand128());
      check("rst_out", out, 128'h0);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // vector 1 then idle: valid drops, data holds
    step(1'b1, VEC1_IN);
    check("vec1_literal", out, VEC1_OUT);
    step(1'b0, 128'h0);
    check("vec1_hold_literal", out, VEC1_OUT);

    // back-to-back
    step(1'b1, VEC1_IN);
    check("b2b_1_literal", out, VEC1_OUT);
    step(1'b1, VEC2_IN);
    check("b2b_2_literal", out, VEC2_OUT);
    check("b2b_2_valid", {127'h0, out_valid}, 128'h1);

    // exhaustive: replicated, then rotated so every lane sees different bytes
    for (int v = 0; v < 256; v++) step(1'b1, {16{8'(v)}});
    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(v + 17*i);
      step(1'b1, s);
    end

    // asynchronous reset mid-stream, between clock edges
    step(1'b1, rand128());
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'h0, out_valid}, 128'h0);
    check("async_rst_out", out, 128'h0);
    exp_q.delete();
    m_out   = 128'h0;
    m_valid = 1'b0;
    step(1'b1, rand128());
    step(1'b1, rand128());
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, VEC2_IN);
    check("post_rst_literal", out, VEC2_OUT);

    // random idle gaps
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), rand128());

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
